// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch stage with one-outstanding memory requests and an instruction buffer
//
// Purpose: owns the PC and fetches instruction words from a variable-latency memory.
//          Returned words are buffered with their PC+4 and handed to decode through a valid/ready handshake.
//          Branch/jump redirects flush buffered work and restart fetch at the new target.
// Ports:
//   clk, rst                    clock and asynchronous active-high reset
//   imem_req/imem_addr          fetch request; the address is held stable until imem_ack
//   imem_ack/imem_rdata         request accepted; the word is valid in the same cycle
//   redirect_valid/_target      restart fetch at target (bits [1:0] forced to zero)
//   instr_valid/instr/instr_pc_plus4/instr_ready
//                               buffer head towards decode; the data outputs are zero when not valid
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc_plus4,
    input  logic        instr_ready
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DISCARD
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   stale_addr_q, stale_addr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [31:0]   fifo_instr_q [FIFO_DEPTH];
    logic [31:0]   fifo_pc4_q   [FIFO_DEPTH];

    logic          ack_fire;
    logic          push;
    logic          pop;
    logic [AW:0]   count_after;
    logic [31:0]   pc_plus4;
    logic          unused_tgt_bits;

    assign unused_tgt_bits = ^redirect_target[1:0];

    assign imem_req       = (state_q != S_IDLE);
    // While discarding, pc_q already holds the redirect target, so the stale address is replayed.
    assign imem_addr      = (state_q == S_DISCARD) ? stale_addr_q : pc_q;
    assign instr_valid    = (count_q != '0);
    assign instr          = instr_valid ? fifo_instr_q[rd_ptr_q] : 32'h0;
    assign instr_pc_plus4 = instr_valid ? fifo_pc4_q[rd_ptr_q] : 32'h0;

    assign ack_fire    = imem_ack & imem_req;
    assign pop         = instr_valid & instr_ready;
    assign push        = ack_fire & (state_q == S_WAIT) & ~redirect_valid;
    assign pc_plus4    = pc_q + 32'd4;
    assign count_after = count_q + (AW + 1)'(push) - (AW + 1)'(pop);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        stale_addr_d = stale_addr_q;
        wr_ptr_d     = wr_ptr_q + AW'(push);
        rd_ptr_d     = rd_ptr_q + AW'(pop);
        count_d      = count_after;

        // A request reserves a buffer slot, so a new one may issue only while the
        // buffered words plus the one in flight still fit.
        case (state_q)
            S_IDLE: begin
                if (count_q < DEPTH_C) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (ack_fire) begin
                    pc_d    = pc_plus4;
                    state_d = (count_after < DEPTH_C) ? S_WAIT : S_IDLE;
                end
            end
            S_DISCARD: begin
                if (ack_fire) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (redirect_valid) begin
            pc_d     = {redirect_target[31:2], 2'b00};
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            case (state_q)
                S_WAIT: begin
                    if (ack_fire) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d      = S_DISCARD;
                        stale_addr_d = pc_q;
                    end
                end
                S_DISCARD: state_d = ack_fire ? S_IDLE : S_DISCARD;
                default:   state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            stale_addr_q <= RESET_PC;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            stale_addr_q <= stale_addr_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    // The payload needs no reset: it is only visible through count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr_q[wr_ptr_q] <= imem_rdata;
            fifo_pc4_q[wr_ptr_q]   <= pc_plus4;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc_plus4;
    logic        instr_ready = 1'b0;

    logic        w_req;
    logic [31:0] w_addr;
    logic        w_valid;
    logic [31:0] w_instr;
    logic [31:0] w_pc4;

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) u_dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .instr_valid(instr_valid), .instr(instr), .instr_pc_plus4(instr_pc_plus4),
        .instr_ready(instr_ready)
    );

    // Second instance with a zero-wait memory that returns the address as data.
    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(DEPTH)) u_dut_wrap (
        .clk(clk), .rst(rst),
        .imem_req(w_req), .imem_addr(w_addr),
        .imem_ack(w_req), .imem_rdata(w_addr),
        .redirect_valid(1'b0), .redirect_target(32'h0),
        .instr_valid(w_valid), .instr(w_instr), .instr_pc_plus4(w_pc4),
        .instr_ready(1'b1)
    );

    int          vectors = 0;
    int          errors = 0;
    int          delivered = 0;
    logic [31:0] salt = 32'h0;
    logic [63:0] exp_q [$];
    logic [31:0] exp_pc;
    bit          discard_pend;
    bit          hold_pend;
    logic [31:0] hold_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ salt;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        exp_pc       = 32'h0;
        discard_pend = 1'b0;
        hold_pend    = 1'b0;
        hold_addr    = 32'h0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; imem_ack = 1'b0; redirect_valid = 1'b0; instr_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // One clock cycle at transaction level: drive the inputs at the falling edge,
    // check the outputs against the expected stream, then advance.
    task automatic cycle(input bit ack_en, input bit rdy, input bit redir, input logic [31:0] tgt);
        imem_ack        = ack_en & imem_req;
        imem_rdata      = mem_word(imem_addr);
        instr_ready     = rdy;
        redirect_valid  = redir;
        redirect_target = tgt;
        #1;
        vectors++;
        if (exp_q.size() + ((imem_req === 1'b1 && !discard_pend) ? 1 : 0) > DEPTH) begin
            errors++; $display("FAIL credit: buffered %0d plus in-flight exceeds %0d", exp_q.size(), DEPTH);
        end
        if (hold_pend) begin
            vectors++;
            if (imem_req !== 1'b1 || imem_addr !== hold_addr) begin
                errors++; $display("FAIL req_hold: req %b addr %h expected req 1 addr %h", imem_req, imem_addr, hold_addr);
            end
        end
        vectors++;
        if (instr_valid !== (exp_q.size() != 0)) begin
            errors++; $display("FAIL instr_valid: got %b expected %b", instr_valid, exp_q.size() != 0);
        end
        if (exp_q.size() != 0) begin
            vectors++;
            if ({instr, instr_pc_plus4} !== exp_q[0]) begin
                errors++; $display("FAIL head: got %h/%h expected %h/%h", instr, instr_pc_plus4, exp_q[0][63:32], exp_q[0][31:0]);
            end
            if (rdy) begin
                void'(exp_q.pop_front());
                delivered++;
            end
        end else begin
            vectors++;
            if ({instr, instr_pc_plus4} !== 64'h0) begin
                errors++; $display("FAIL idle_zero: got %h/%h expected 0/0", instr, instr_pc_plus4);
            end
        end
        if (imem_req === 1'b1 && imem_ack) begin
            if (discard_pend || redir) begin
                discard_pend = 1'b0;
            end else begin
                vectors++;
                if (imem_addr !== exp_pc) begin
                    errors++; $display("FAIL fetch_addr: got %h expected %h", imem_addr, exp_pc);
                end
                exp_q.push_back({mem_word(exp_pc), exp_pc + 32'd4});
                exp_pc = exp_pc + 32'd4;
            end
        end
        if (redir) begin
            exp_q.delete();
            exp_pc = {tgt[31:2], 2'b00};
            if (imem_req === 1'b1 && !imem_ack) discard_pend = 1'b1;
        end
        hold_pend = (imem_req === 1'b1) && !imem_ack;
        hold_addr = imem_addr;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        vectors++;
        if ({imem_req, instr_valid, instr, instr_pc_plus4} !== 66'h0) begin
            errors++; $display("FAIL reset_outputs: req %b valid %b instr %h pc4 %h expected all 0", imem_req, instr_valid, instr, instr_pc_plus4);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        vectors++;
        if (imem_req !== 1'b0) begin
            errors++; $display("FAIL req_before_edge: got %b expected 0", imem_req);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++; $display("FAIL first_req: req %b addr %h expected 1 00000000", imem_req, imem_addr);
        end
        @(negedge clk);
    endtask

    task automatic test_stream();
        do_reset();
        salt = 32'h0;
        cycle(1, 1, 0, 32'h0);
        for (int k = 0; k < 8; k++) begin
            vectors++;
            if (imem_req !== 1'b1 || imem_addr !== 32'(4 * k)) begin
                errors++; $display("FAIL stream_addr: req %b addr %h expected 1 %h", imem_req, imem_addr, 32'(4 * k));
            end
            if (k >= 1) begin
                vectors++;
                if (instr_valid !== 1'b1 || instr !== 32'(4 * (k - 1)) || instr_pc_plus4 !== 32'(4 * k)) begin
                    errors++; $display("FAIL stream_instr: valid %b instr %h pc4 %h expected 1 %h %h", instr_valid, instr, instr_pc_plus4, 32'(4 * (k - 1)), 32'(4 * k));
                end
            end
            cycle(1, 1, 0, 32'h0);
        end
    endtask

    task automatic test_backpressure();
        int n = 0;
        do_reset();
        salt = 32'h0;
        cycle(1, 0, 0, 32'h0);
        repeat (6) begin
            if (imem_req === 1'b1) n++;
            cycle(1, 0, 0, 32'h0);
        end
        vectors++;
        if (n !== DEPTH || imem_req !== 1'b0) begin
            errors++; $display("FAIL bp_requests: issued %0d req %b expected %0d 0", n, imem_req, DEPTH);
        end
        vectors++;
        if (instr_valid !== 1'b1 || instr !== 32'h0) begin
            errors++; $display("FAIL bp_head: valid %b instr %h expected 1 00000000", instr_valid, instr);
        end
        cycle(1, 1, 0, 32'h0);
        vectors++;
        if (instr !== 32'h4) begin
            errors++; $display("FAIL bp_second: got %h expected 00000004", instr);
        end
        cycle(1, 1, 0, 32'h0);
    endtask

    task automatic test_redirect_wait();
        do_reset();
        salt = 32'h0;
        cycle(0, 1, 0, 32'h0);
        cycle(0, 1, 0, 32'h0);
        cycle(0, 1, 1, 32'h0000_0103);
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++; $display("FAIL discard_hold: req %b addr %h expected 1 00000000", imem_req, imem_addr);
        end
        cycle(0, 1, 0, 32'h0);
        cycle(1, 1, 0, 32'h0);
        vectors++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            errors++; $display("FAIL discard_drop: req %b valid %b expected 0 0", imem_req, instr_valid);
        end
        cycle(1, 1, 0, 32'h0);
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0100) begin
            errors++; $display("FAIL redirect_addr: req %b addr %h expected 1 00000100", imem_req, imem_addr);
        end
        cycle(1, 1, 0, 32'h0);
        vectors++;
        if (instr_valid !== 1'b1 || instr !== 32'h100 || instr_pc_plus4 !== 32'h104) begin
            errors++; $display("FAIL redirect_instr: valid %b instr %h pc4 %h expected 1 00000100 00000104", instr_valid, instr, instr_pc_plus4);
        end
        cycle(1, 1, 0, 32'h0);
    endtask

    task automatic test_redirect_ack_pop();
        do_reset();
        salt = 32'h0;
        cycle(1, 1, 0, 32'h0);
        cycle(1, 1, 0, 32'h0);
        cycle(1, 1, 1, 32'h0000_0200);
        vectors++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin
            errors++; $display("FAIL flush: valid %b req %b expected 0 0", instr_valid, imem_req);
        end
        cycle(1, 1, 0, 32'h0);
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0200) begin
            errors++; $display("FAIL flush_refetch: req %b addr %h expected 1 00000200", imem_req, imem_addr);
        end
        cycle(1, 1, 0, 32'h0);
        cycle(1, 1, 0, 32'h0);
    endtask

    task automatic test_wrap();
        do_reset();
        cycle(0, 1, 0, 32'h0);
        vectors++;
        if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFFC) begin
            errors++; $display("FAIL wrap_first: req %b addr %h expected 1 fffffffc", w_req, w_addr);
        end
        cycle(0, 1, 0, 32'h0);
        vectors++;
        if (w_valid !== 1'b1 || w_instr !== 32'hFFFF_FFFC || w_pc4 !== 32'h0 || w_addr !== 32'h0) begin
            errors++; $display("FAIL wrap_second: valid %b instr %h pc4 %h addr %h expected 1 fffffffc 00000000 00000000", w_valid, w_instr, w_pc4, w_addr);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        salt = 32'h0;
        cycle(1, 1, 0, 32'h0);
        cycle(1, 0, 0, 32'h0);
        imem_ack = 1'b1;
        rst = 1'b1;
        #1;
        vectors++;
        if ({imem_req, instr_valid, instr, instr_pc_plus4} !== 66'h0) begin
            errors++; $display("FAIL midreset_outputs: req %b valid %b instr %h pc4 %h expected all 0", imem_req, instr_valid, instr, instr_pc_plus4);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        vectors++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++; $display("FAIL midreset_refetch: valid %b req %b addr %h expected 0 1 00000000", instr_valid, imem_req, imem_addr);
        end
        repeat (4) cycle(1, 1, 0, 32'h0);
    endtask

    task automatic test_random();
        int  lat;
        bit  ack_en;
        int  start;
        do_reset();
        salt  = $urandom;
        lat   = $urandom_range(0, 3);
        start = delivered;
        for (int i = 0; i < 600; i++) begin
            ack_en = 1'b0;
            if (imem_req === 1'b1) begin
                if (lat == 0) begin
                    ack_en = 1'b1;
                    lat    = $urandom_range(0, 3);
                end else begin
                    lat--;
                end
            end
            cycle(ack_en, $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, $urandom);
        end
        vectors++;
        if (delivered - start < 60) begin
            errors++; $display("FAIL random_progress: delivered %0d expected at least 60", delivered - start);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_wait();
        test_redirect_ack_pop();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
